// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline writeback and queued accelerator results onto one register-file write port.
// Optional WAW kill of queued entries by younger pipeline writes: define WB_WAW_KILL_EN.
`default_nettype none

module wb_arbiter #(
   parameter int ACC_DEPTH = 2,
   parameter int DW        = 19
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pipe_wen,
   input  logic [2:0]    pipe_rd,
   input  logic [DW-1:0] pipe_data,
   input  logic          acc_valid,
   output logic          acc_ready,
   input  logic [2:0]    acc_rd,
   input  logic [DW-1:0] acc_data,
   output logic          reg_write,
   output logic [2:0]    rd_addr,
   output logic [DW-1:0] wb_data,
   output logic [7:0]    pending_mask
);

   localparam logic [2:0] c_DEPTH = 3'(ACC_DEPTH);
   localparam logic [1:0] c_LAST  = 2'(ACC_DEPTH - 1);

   // Storage is sized for the largest legal depth so 2-bit pointers index it cleanly.
   logic          r_live [4];
   logic [2:0]    r_rd   [4];
   logic [DW-1:0] r_data [4];
   logic [1:0]    r_wptr;
   logic [1:0]    r_rptr;
   logic [2:0]    r_count;

   logic w_pipe;
   logic w_nonempty;
   logic w_head_hit;
   logic w_head_live;
   logic w_pop;
   logic w_push;

   assign acc_ready  = (r_count < c_DEPTH);
   assign w_pipe     = pipe_wen && (pipe_rd != 3'd0);
   assign w_nonempty = (r_count != 3'd0);
   assign w_push     = acc_valid && acc_ready && (acc_rd != 3'd0);

`ifdef WB_WAW_KILL_EN
   assign w_head_hit = w_pipe && (r_rd[r_rptr] == pipe_rd);
`else
   assign w_head_hit = 1'b0;
`endif

   assign w_head_live = w_nonempty && r_live[r_rptr] && !w_head_hit;
   // A dead head always drains; a live head only drains when the pipeline leaves the port free.
   assign w_pop       = w_nonempty && (!w_head_live || !w_pipe);

   always_comb begin
      pending_mask = 8'h00;
      for (int i = 0; i < 4; i++) begin
         if (r_live[i]) pending_mask[r_rd[i]] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write <= 1'b0;
         rd_addr   <= 3'd0;
         wb_data   <= '0;
         r_wptr    <= 2'd0;
         r_rptr    <= 2'd0;
         r_count   <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            r_live[i] <= 1'b0;
            r_rd[i]   <= 3'd0;
            r_data[i] <= '0;
         end
      end else begin
         if (w_pipe) begin
            reg_write <= 1'b1;
            rd_addr   <= pipe_rd;
            wb_data   <= pipe_data;
         end else if (w_head_live) begin
            reg_write <= 1'b1;
            rd_addr   <= r_rd[r_rptr];
            wb_data   <= r_data[r_rptr];
         end else begin
            reg_write <= 1'b0;
         end

`ifdef WB_WAW_KILL_EN
         for (int i = 0; i < 4; i++) begin
            if (w_pipe && (r_rd[i] == pipe_rd)) r_live[i] <= 1'b0;
         end
`endif

         if (w_pop) begin
            r_live[r_rptr] <= 1'b0;
            r_rptr         <= (r_rptr == c_LAST) ? 2'd0 : r_rptr + 2'd1;
         end

         // Written last so a same-cycle enqueue is younger than the pipeline write and survives it.
         if (w_push) begin
            r_live[r_wptr] <= 1'b1;
            r_rd[r_wptr]   <= acc_rd;
            r_data[r_wptr] <= acc_data;
            r_wptr         <= (r_wptr == c_LAST) ? 2'd0 : r_wptr + 2'd1;
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus, queue-level reference model checked every cycle, plus literal expectations.
`default_nettype none

module tb_wb_arbiter;

   localparam int ACC_DEPTH = 2;
   localparam int DW        = 19;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pipe_wen = 1'b0;
   logic [2:0]    pipe_rd = 3'd0;
   logic [DW-1:0] pipe_data = '0;
   logic          acc_valid = 1'b0;
   logic          acc_ready;
   logic [2:0]    acc_rd = 3'd0;
   logic [DW-1:0] acc_data = '0;
   logic          reg_write;
   logic [2:0]    rd_addr;
   logic [DW-1:0] wb_data;
   logic [7:0]    pending_mask;

   int checks = 0;
   int errors = 0;

   wb_arbiter #(.ACC_DEPTH(ACC_DEPTH), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_rd(acc_rd), .acc_data(acc_data),
      .reg_write(reg_write), .rd_addr(rd_addr), .wb_data(wb_data), .pending_mask(pending_mask)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of results; kills mark entries dead, dead heads are discarded.
   typedef struct packed {
      logic [2:0]    rd;
      logic [DW-1:0] data;
      logic          live;
   } ent_t;

   ent_t          mq[$];
   logic          m_we   = 1'b0;
   logic [2:0]    m_rd   = 3'd0;
   logic [DW-1:0] m_data = '0;

   // Inputs change only just after a falling edge, so here they still show what the last rising edge sampled.
   always @(negedge clk) begin : compare
      logic   rdy;
      logic   pw;
      logic [7:0] pm;
      if (rst) begin
         mq.delete();
         m_we   = 1'b0;
         m_rd   = 3'd0;
         m_data = '0;
      end else begin
         rdy = (mq.size() < ACC_DEPTH);
         pw  = pipe_wen && (pipe_rd != 3'd0);
`ifdef WB_WAW_KILL_EN
         if (pw) foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].live = 1'b0;
`endif
         m_we = 1'b0;
         if (pw) begin
            m_we = 1'b1; m_rd = pipe_rd; m_data = pipe_data;
            if (mq.size() > 0 && !mq[0].live) void'(mq.pop_front());
         end else if (mq.size() > 0) begin
            if (mq[0].live) begin
               m_we = 1'b1; m_rd = mq[0].rd; m_data = mq[0].data;
            end
            void'(mq.pop_front());
         end
         if (acc_valid && rdy && acc_rd != 3'd0) mq.push_back('{rd: acc_rd, data: acc_data, live: 1'b1});
      end
      pm = 8'h00;
      foreach (mq[i]) if (mq[i].live) pm[mq[i].rd] = 1'b1;
      chk("model_reg_write", int'(reg_write), int'(m_we));
      chk("model_rd_addr", int'(rd_addr), int'(m_rd));
      chk("model_wb_data", int'(wb_data), int'(m_data));
      chk("model_acc_ready", int'(acc_ready), int'(mq.size() < ACC_DEPTH));
      chk("model_pending", int'(pending_mask), int'(pm));
   end

   task automatic step(input logic pw, input logic [2:0] prd, input logic [DW-1:0] pd,
                       input logic av, input logic [2:0] ard, input logic [DW-1:0] ad);
      pipe_wen = pw; pipe_rd = prd; pipe_data = pd;
      acc_valid = av; acc_rd = ard; acc_data = ad;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
   endtask

   task automatic expect_wr(input string name, input logic [2:0] rd, input logic [DW-1:0] d);
      chk({name, "_we"}, int'(reg_write), 1);
      chk({name, "_rd"}, int'(rd_addr), int'(rd));
      chk({name, "_data"}, int'(wb_data), int'(d));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         idle();
         chk("idle_ready", int'(acc_ready), 1);
         chk("idle_we", int'(reg_write), 0);
         chk("idle_pending", int'(pending_mask), 0);
      end

      // Pipeline only, then r0 ignored
      step(1'b1, 3'd3, 19'h12345, 1'b0, 3'd0, '0);
      expect_wr("pipe_r3", 3'd3, 19'h12345);
      idle();
      chk("pipe_after_we", int'(reg_write), 0);
      step(1'b1, 3'd0, 19'h12345, 1'b0, 3'd0, '0);
      chk("pipe_r0_we", int'(reg_write), 0);
      idle();
      chk("pipe_r0_after_we", int'(reg_write), 0);

      // Back-pressure with pipeline holding the port
      step(1'b1, 3'd1, 19'h00011, 1'b1, 3'd5, 19'h00AAA);
      chk("bp_ready1", int'(acc_ready), 1);
      chk("bp_pending1", int'(pending_mask), 8'h20);
      step(1'b1, 3'd1, 19'h00012, 1'b1, 3'd6, 19'h00BBB);
      chk("bp_ready2", int'(acc_ready), 0);
      chk("bp_pending2", int'(pending_mask), 8'h60);
      step(1'b1, 3'd1, 19'h00013, 1'b1, 3'd7, 19'h00CCC);
      chk("bp_ready3", int'(acc_ready), 0);
      step(1'b1, 3'd1, 19'h00014, 1'b0, 3'd0, '0);
      chk("bp_pending4", int'(pending_mask), 8'h60);
      idle();
      expect_wr("bp_r5", 3'd5, 19'h00AAA);
      chk("bp_ready_back", int'(acc_ready), 1);
      idle();
      expect_wr("bp_r6", 3'd6, 19'h00BBB);
      chk("bp_pending_clr", int'(pending_mask), 0);
      idle();
      chk("bp_done_we", int'(reg_write), 0);

      // Simultaneous pipeline and accelerator
      step(1'b1, 3'd4, 19'h00444, 1'b1, 3'd2, 19'h00222);
      expect_wr("sim_r4", 3'd4, 19'h00444);
      idle();
      expect_wr("sim_r2", 3'd2, 19'h00222);
      idle();
      chk("sim_done_we", int'(reg_write), 0);

      // WAW
      step(1'b0, 3'd0, '0, 1'b1, 3'd2, 19'h00111);
      chk("waw_q_we", int'(reg_write), 0);
      chk("waw_q_pending", int'(pending_mask), 8'h04);
      step(1'b1, 3'd2, 19'h00222, 1'b0, 3'd0, '0);
      expect_wr("waw_pipe", 3'd2, 19'h00222);
`ifdef WB_WAW_KILL_EN
      chk("waw_kill_pending", int'(pending_mask), 0);
      idle();
      chk("waw_kill_no_write", int'(reg_write), 0);
`else
      chk("waw_keep_pending", int'(pending_mask), 8'h04);
      idle();
      expect_wr("waw_late", 3'd2, 19'h00111);
      chk("waw_late_pending", int'(pending_mask), 0);
`endif
      idle();

      // Reset mid-operation
      step(1'b1, 3'd1, 19'h00021, 1'b1, 3'd5, 19'h00055);
      step(1'b1, 3'd1, 19'h00022, 1'b1, 3'd6, 19'h00066);
      chk("rst_pre_pending", int'(pending_mask), 8'h60);
      pipe_wen = 1'b0; acc_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_now_we", int'(reg_write), 0);
      chk("rst_now_pending", int'(pending_mask), 0);
      chk("rst_now_ready", int'(acc_ready), 1);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         idle();
         chk("rst_after_we", int'(reg_write), 0);
      end

      // Mixed directed pattern, checked by the model
      for (int i = 0; i < 150; i++) begin
         step(1'((i % 5 == 1) || (i % 7 == 3)), 3'(i % 8), DW'(i * 37),
              1'(i % 3 != 0), 3'((i * 5) % 8), DW'(i * 11 + 1));
      end
      for (int i = 0; i < 6; i++) idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execute/memory pipeline and the 8×19-bit register file. It merges two result sources onto the register file's single write port:
- the in-order pipeline writeback, which can never stall;
- results from the multi-cycle FFT/crypto accelerator, which are buffered in a small queue.

It exposes a pending-register mask for the hazard logic and drives the register file's write port from registers.

## Interface
Parameters:
- ACC_DEPTH, 2: accelerator result queue depth; legal range 1–4.
- DW, 19: data width. Must match the register file word.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst, in, 1: reset, asynchronous and active-high.
- pipe_wen, in, 1: pipeline result valid this cycle.
- pipe_rd, in, 3: pipeline destination register.
- pipe_data, in, DW: pipeline result.
- acc_valid, in, 1: accelerator offers a result.
- acc_ready, out, 1: queue can accept a result; transfer occurs when acc_valid && acc_ready.
- acc_rd, in, 3: accelerator destination register.
- acc_data, in, DW: accelerator result.
- reg_write, out, 1: register file write enable (registered).
- rd_addr, out, 3: register file write address (registered).
- wb_data, out, DW: register file write data (registered).
- pending_mask, out, 8: bit i set while any live queued entry targets register i.

## Operation
**Queue**
- Circular FIFO of ACC_DEPTH entries; each entry holds {live, rd, data}.
- Read/write pointers wrap modulo ACC_DEPTH.
- Occupancy count runs 0..ACC_DEPTH.
- acc_ready = (count < ACC_DEPTH), taken from registered state only, with no combinational path from pop.
- A full queue therefore refuses an offer even in a cycle where it pops.

**Enqueue**
- On each accepted transfer, store {1, acc_rd, acc_data}.
- If acc_rd == 0, the transfer is accepted but nothing is stored (r0 writes are dropped).

**Arbitration** (at most one register file write per cycle)
- If pipe_wen && pipe_rd != 0: the next outputs are {1, pipe_rd, pipe_data}. The pipeline always wins.
- Else, if the queue is non-empty and the head is live: the next outputs are {1, head.rd, head.data}, and the head is popped.
- Else: the next reg_write is 0. rd_addr and wb_data hold their previous values.
- A dead (killed) head pops in any cycle, including a cycle with a pipeline write, and produces no write. At most one pop per cycle.
- pipe_wen with pipe_rd == 0 is ignored completely.

**WAW kill** (only with WB_WAW_KILL_EN)
- A pipeline write to register X clears the live bit of every queued entry with rd == X.
- The pipeline write is treated as younger than all entries already in the queue.
- An entry enqueued in the same cycle as the pipeline write is treated as younger and is not killed.
- A head killed in the current cycle pops that cycle without writing.

**pending_mask**
- OR over live entries of onehot(rd), computed combinationally from registered queue state.

## Timing
- Reset values: reg_write=0, rd_addr=0, wb_data=0, count=0, both pointers=0, all live bits=0, pending_mask=0, acc_ready=1.
- Pipeline path: sampled at edge N; reg_write is high during cycle N+1; the register file commits at edge N+1. Latency is 1.
- Accelerator path: enqueued at edge N; earliest pop at edge N+1; reg_write is high during cycle N+2. Minimum latency is 2; it grows by 1 per cycle the pipeline blocks the head.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- Asserting rst mid-operation discards all queued results immediately; no partial write is issued after deassertion.

## Configuration
- WB_WAW_KILL_EN defined: WAW kill logic is present, as described under Operation.
- WB_WAW_KILL_EN undefined: live bits are never cleared by pipeline writes. Every queued entry (other than r0, which is never stored) eventually writes in FIFO order, and software must avoid WAW conflicts with outstanding accelerator ops.
- pending_mask behaves identically in both builds, apart from kills.

## Test plan
- Reset, then idle: acc_ready=1, reg_write=0, pending_mask=0x00 for 10 cycles.
- Pipeline only: pipe_wen, rd=3, data=0x12345 at edge N → reg_write=1, rd_addr=3, wb_data=0x12345 in cycle N+1, then reg_write=0. The same stimulus with rd=0 never raises reg_write.
- Back-pressure: ACC_DEPTH=2; accelerator writes r5=0x00AAA and r6=0x00BBB while pipe_wen is held high for 4 cycles → acc_ready=0 after the second accept, pending_mask=0x60. After pipe_wen drops: r5 written, then r6, in consecutive cycles; acc_ready returns to 1.
- Simultaneous: acc_valid to r2 and pipe_wen to r4 in the same cycle → r4 written first, r2 the next cycle.
- WAW kill (macro on): queue r2=0x00111; next cycle the pipeline writes r2=0x00222 → exactly one write, r2=0x00222; pending_mask bit 2 clears. With the macro off: r2=0x00222, then r2=0x00111.
- Reset mid-operation: two queued entries, assert rst → pending_mask=0 and reg_write=0 immediately; no writes after release.
